sqrt_pipe_hs: RTL and testbench

Parametrised sequential integer square root engine; next generation of the 8-bit sqrt unit.
- Computes floor(sqrt(x)) and remainder for a WIDTH-bit unsigned operand, one root bit per cycle (binary digit-by-digit, restoring).
- Adds valid/ready handshakes on both sides, optional round-to-nearest and a functional stall enable (no clock gating).
- Sits between a producer FIFO and consumer logic on the single core clock.

---
 rtl/sqrt_hs_pkg.sv | 20 ++
 rtl/sqrt_hs_dp.sv | 88 ++++++++
 rtl/sqrt_pipe_hs.sv | 101 ++++++++++
 tb/tb_sqrt_pipe_hs.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sqrt_hs_pkg.sv
// Shared types and elaboration helpers for the handshaked square-root engine.
package sqrt_hs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Operand width must be even (two operand bits per root bit) and at least 4.
  function automatic bit width_ok(input int w);
    return ((w % 2) == 0) && (w >= 4);
  endfunction

  // Width of the step counter, which counts RW-1 down to 0.
  function automatic int cnt_width(input int rw);
    return (rw > 2) ? $clog2(rw) : 1;
  endfunction

endpackage

// File: rtl/sqrt_hs_dp.sv
// Datapath: operand/root/remainder registers, one restoring digit step per
// enabled cycle, and the result registers loaded on the final step.
module sqrt_hs_dp
  import sqrt_hs_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int RW    = WIDTH / 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             cap_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             round_i,
  output logic [RW-1:0]    root_o,
  output logic [RW:0]      rem_o,
  output logic             sat_o
);

  logic [WIDTH-1:0] r_op;
  logic [RW-1:0]    r_root;
  // The partial remainder is bounded by 2*partial_root < 2^RW until the last step.
  logic [RW-1:0]    r_rem;
  logic             r_round;
  logic [RW-1:0]    r_root_out;
  logic [RW:0]      r_rem_out;
  logic             r_sat_out;

  logic [RW+1:0]    w_trial;
  logic [RW+1:0]    w_cmp;
  logic             w_ge;
  logic [RW:0]      w_diff;
  logic [RW:0]      w_rem_nxt;
  logic [RW-1:0]    w_root_nxt;
  logic             w_round_up;
  logic             w_root_max;
  logic             w_sat;
  logic [RW-1:0]    w_root_fin;

  // One digit step: bring down two operand bits and try to subtract 4*root+1.
  assign w_trial    = {r_rem, r_op[WIDTH-1:WIDTH-2]};
  assign w_cmp      = {r_root, 2'b01};
  assign w_ge       = (w_trial >= w_cmp);
  // The difference never exceeds 2*root, so RW+1 bits hold it exactly.
  assign w_diff     = w_trial[RW:0] - w_cmp[RW:0];
  assign w_rem_nxt  = w_ge ? w_diff : w_trial[RW:0];
  assign w_root_nxt = {r_root[RW-2:0], w_ge};

  // Round to nearest: sqrt(x) >= r + 0.5 exactly when rem > r.
  assign w_round_up = r_round & (w_rem_nxt > {1'b0, w_root_nxt});
  assign w_root_max = &w_root_nxt;
  assign w_sat      = w_round_up & w_root_max;
  assign w_root_fin = (w_round_up & ~w_root_max) ?
                      (w_root_nxt + {{(RW-1){1'b0}}, 1'b1}) : w_root_nxt;

  // Operand load, iteration registers and result capture on the final step.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_op       <= {WIDTH{1'b0}};
      r_root     <= {RW{1'b0}};
      r_rem      <= {RW{1'b0}};
      r_round    <= 1'b0;
      r_root_out <= {RW{1'b0}};
      r_rem_out  <= {(RW+1){1'b0}};
      r_sat_out  <= 1'b0;
    end else if (load_i) begin
      r_op    <= data_i;
      r_round <= round_i;
      r_root  <= {RW{1'b0}};
      r_rem   <= {RW{1'b0}};
    end else if (step_i) begin
      r_op   <= {r_op[WIDTH-3:0], 2'b00};
      r_root <= w_root_nxt;
      r_rem  <= w_rem_nxt[RW-1:0];
      if (cap_i) begin
        r_root_out <= w_root_fin;
        r_rem_out  <= w_rem_nxt;
        r_sat_out  <= w_sat;
      end
    end
  end

  assign root_o = r_root_out;
  assign rem_o  = r_rem_out;
  assign sat_o  = r_sat_out;

endmodule

// File: rtl/sqrt_pipe_hs.sv
// Sequential integer square root with valid/ready handshakes, optional
// round-to-nearest, functional enable and synchronous abort.
module sqrt_pipe_hs
  import sqrt_hs_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int RW    = WIDTH / 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enb_i,
  input  logic             clear_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] data_i,
  input  logic             round_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [RW-1:0]    root_o,
  output logic [RW:0]      rem_o,
  output logic             sat_o,
  output logic             busy_o
);

  localparam int CW = cnt_width(RW);

  if (!width_ok(WIDTH)) begin : g_width_chk
    $error("sqrt_pipe_hs: WIDTH must be even and >= 4");
  end

  state_e        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_out_valid;

  logic          w_accept;
  logic          w_step;
  logic          w_last;

  // Handshake and step qualifiers; clear and a low enable block all of them.
  assign in_ready_o = (r_state == ST_IDLE) & enb_i & ~clear_i & ~rst_i;
  assign w_accept   = (r_state == ST_IDLE) & enb_i & ~clear_i & in_valid_i;
  assign w_step     = (r_state == ST_CALC) & enb_i & ~clear_i;
  assign w_last     = w_step & (r_cnt == {CW{1'b0}});

  // Control FSM: accept in IDLE, one root bit per enabled cycle, hold in DONE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_cnt       <= {CW{1'b0}};
      r_out_valid <= 1'b0;
    end else if (clear_i) begin
      r_state     <= ST_IDLE;
      r_cnt       <= {CW{1'b0}};
      r_out_valid <= 1'b0;
    end else if (enb_i) begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid_i) begin
            r_state <= ST_CALC;
            r_cnt   <= CW'(RW - 1);
          end
        end
        ST_CALC: begin
          if (r_cnt == {CW{1'b0}}) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - {{(CW-1){1'b0}}, 1'b1};
          end
        end
        ST_DONE: begin
          if (out_ready_i) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  sqrt_hs_dp #(.WIDTH(WIDTH)) u_dp (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (w_accept),
    .step_i  (w_step),
    .cap_i   (w_last),
    .data_i  (data_i),
    .round_i (round_i),
    .root_o  (root_o),
    .rem_o   (rem_o),
    .sat_o   (sat_o)
  );

  assign out_valid_o = r_out_valid;
  assign busy_o      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sqrt_pipe_hs.sv
// Self-checking bench for sqrt_pipe_hs: directed cases, stalls, clear/reset
// and randomized traffic against a behavioural square-root model.
module tb_sqrt_pipe_hs;

  localparam int RA = 8;   // root width of the 16-bit instance
  localparam int RB = 4;   // root width of the 8-bit instance

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, enb, clr, in_valid, round, out_ready;
  logic [15:0] data;
  logic        in_ready, out_valid, sat, busy;
  logic [7:0]  root;
  logic [8:0]  rem;

  logic        b_enb, b_clr, b_in_valid, b_round, b_out_ready;
  logic [7:0]  b_data;
  logic        b_in_ready, b_out_valid, b_sat, b_busy;
  logic [3:0]  b_root;
  logic [4:0]  b_rem;

  int n_cmp  = 0;
  int n_fail = 0;

  sqrt_pipe_hs #(.WIDTH(16)) dut (
    .clk_i(clk), .rst_i(rst), .enb_i(enb), .clear_i(clr),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .data_i(data), .round_i(round),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .root_o(root), .rem_o(rem), .sat_o(sat), .busy_o(busy)
  );

  sqrt_pipe_hs #(.WIDTH(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .enb_i(b_enb), .clear_i(b_clr),
    .in_valid_i(b_in_valid), .in_ready_o(b_in_ready), .data_i(b_data), .round_i(b_round),
    .out_valid_o(b_out_valid), .out_ready_i(b_out_ready),
    .root_o(b_root), .rem_o(b_rem), .sat_o(b_sat), .busy_o(b_busy)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: largest r with r*r <= x; round up when 4x > (2r+1)^2.
  function automatic void ref_sqrt(input longint x, input bit rnd, input int rw,
                                   output longint rt, output longint rm, output longint st);
    longint r;
    r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    rm = x - r * r;
    rt = r;
    st = 0;
    if (rnd && (4 * x > (2 * r + 1) * (2 * r + 1))) begin
      if (r == (longint'(1) << rw) - 1) st = 1;
      else rt = r + 1;
    end
  endfunction

  // Transaction-level model of the 16-bit instance.
  bit     m_busy   = 1'b0;
  int     m_edges  = 0;
  longint j_root = 0, j_rem = 0, j_sat = 0;
  longint h_root = 0, h_rem = 0, h_sat = 0;

  // Compare DUT against the model every cycle, then advance the model for the next edge.
  always @(negedge clk) begin
    if (rst) begin
      m_busy = 1'b0; m_edges = 0;
      h_root = 0; h_rem = 0; h_sat = 0;
    end
    chk("in_ready", in_ready, !m_busy && enb && !clr && !rst);
    chk("busy", busy, m_busy);
    chk("out_valid", out_valid, m_busy && (m_edges >= RA));
    chk("root", root, h_root);
    chk("rem", rem, h_rem);
    chk("sat", sat, h_sat);
    if (!rst) begin
      if (clr) begin
        m_busy = 1'b0;
      end else if (enb) begin
        if (!m_busy) begin
          if (in_valid) begin
            m_busy = 1'b1; m_edges = 0;
            ref_sqrt(data, round, RA, j_root, j_rem, j_sat);
          end
        end else if (m_edges < RA) begin
          m_edges++;
          if (m_edges == RA) begin
            h_root = j_root; h_rem = j_rem; h_sat = j_sat;
          end
        end else if (out_ready) begin
          m_busy = 1'b0;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic accept16(input logic [15:0] d, input logic r, input string nm);
    int g;
    in_valid = 1'b1; data = d; round = r; g = 0;
    while (!in_ready && g < 40) begin cyc(); g++; end
    chk({nm, "_accept_timeout"}, g < 40, 1);
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic job16(input logic [15:0] d, input logic r, input longint e_root,
                       input longint e_rem, input longint e_sat, input int e_lat,
                       input int stall_at, input int stall_len, input int hold, input string nm);
    int lat;
    accept16(d, r, nm);
    lat = 0;
    while (!out_valid && lat < 60) begin
      if (lat == stall_at) enb = 1'b0;
      if (lat == stall_at + stall_len) enb = 1'b1;
      cyc(); lat++;
    end
    enb = 1'b1;
    chk({nm, "_latency"}, lat, e_lat);
    chk({nm, "_root"}, root, e_root);
    chk({nm, "_rem"}, rem, e_rem);
    chk({nm, "_sat"}, sat, e_sat);
    repeat (hold) begin
      cyc();
      chk({nm, "_hold_valid"}, out_valid, 1);
      chk({nm, "_hold_root"}, root, e_root);
    end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk({nm, "_released"}, out_valid, 0);
    cyc();
    chk({nm, "_single_xfer"}, out_valid, 0);
  endtask

  task automatic job8(input logic [7:0] d, input logic r, input longint e_root,
                      input longint e_rem, input longint e_sat, input int e_lat, input string nm);
    int g;
    int lat;
    b_in_valid = 1'b1; b_data = d; b_round = r; g = 0;
    while (!b_in_ready && g < 40) begin cyc(); g++; end
    chk({nm, "_accept_timeout"}, g < 40, 1);
    cyc();
    b_in_valid = 1'b0;
    lat = 0;
    while (!b_out_valid && lat < 40) begin cyc(); lat++; end
    chk({nm, "_latency"}, lat, e_lat);
    chk({nm, "_root"}, b_root, e_root);
    chk({nm, "_rem"}, b_rem, e_rem);
    chk({nm, "_sat"}, b_sat, e_sat);
    b_out_ready = 1'b1;
    cyc();
    b_out_ready = 1'b0;
    chk({nm, "_released"}, b_out_valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    longint er, em, es;
    int     g;
    logic [7:0] d8;
    logic       r8;

    rst = 1'b1; enb = 1'b1; clr = 1'b0; in_valid = 1'b0; round = 1'b0;
    out_ready = 1'b0; data = 16'd0;
    b_enb = 1'b1; b_clr = 1'b0; b_in_valid = 1'b0; b_round = 1'b0;
    b_out_ready = 1'b0; b_data = 8'd0;
    repeat (3) cyc();
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_root", root, 0);
    chk("reset_rem", rem, 0);
    chk("reset_busy", busy, 0);
    rst = 1'b0;
    cyc();

    // 16-bit directed cases with hand-computed results.
    job16(16'd0,     1'b0, 0,   0,   0, 8,  -1, 0, 0, "zero");
    job16(16'd210,   1'b1, 14,  14,  0, 8,  -1, 0, 0, "d210_rnd");
    job16(16'd211,   1'b1, 15,  15,  0, 8,  -1, 0, 0, "d211_rnd");
    job16(16'd65535, 1'b1, 255, 510, 1, 8,  -1, 0, 0, "max_rnd");
    job16(16'd65535, 1'b0, 255, 510, 0, 8,  -1, 0, 0, "max_trunc");
    job16(16'd40000, 1'b0, 200, 0,   0, 11,  2, 3, 5, "stall");

    // 8-bit instance: directed, then random against the model.
    job8(8'd255, 1'b0, 15, 30, 0, 4, "w8_255");
    job8(8'd200, 1'b0, 14, 4,  0, 4, "w8_200");
    job8(8'd255, 1'b1, 15, 30, 1, 4, "w8_255_rnd");
    for (int i = 0; i < 30; i++) begin
      d8 = 8'($urandom_range(0, 255));
      r8 = 1'($urandom_range(0, 1));
      ref_sqrt(d8, r8, RB, er, em, es);
      job8(d8, r8, er, em, es, 4, "w8_rand");
    end

    // Clear during CALC, and clear blocking a simultaneous input handshake.
    accept16(16'd12345, 1'b0, "clr_job");
    repeat (3) cyc();
    clr = 1'b1;
    cyc();
    chk("clr_out_valid", out_valid, 0);
    chk("clr_busy", busy, 0);
    in_valid = 1'b1; data = 16'd999;
    cyc();
    chk("clr_blocks_accept", busy, 0);
    clr = 1'b0; in_valid = 1'b0;
    cyc();

    // Reset asserted while a result is waiting in DONE.
    accept16(16'd100, 1'b0, "rst_job");
    g = 0;
    while (!out_valid && g < 40) begin cyc(); g++; end
    chk("rst_job_done", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_root_cleared", root, 0);
    cyc();
    rst = 1'b0;
    cyc();
    job16(16'd16, 1'b0, 4, 0, 0, 8, -1, 0, 0, "after_rst");

    // Randomized traffic; the compare process checks every cycle.
    for (int i = 0; i < 2500; i++) begin
      enb       = ($urandom_range(0, 7) != 0);
      clr       = ($urandom_range(0, 63) == 0);
      rst       = ($urandom_range(0, 499) == 0);
      in_valid  = 1'($urandom_range(0, 1));
      round     = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0:       data = 16'hFFFF;
        1:       data = 16'd0;
        2:       data = 16'($urandom_range(0, 255) * $urandom_range(0, 255));
        default: data = 16'($urandom);
      endcase
      cyc();
    end
    rst = 1'b0; clr = 1'b0; enb = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (20) cyc();
    chk("drain_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
